operand_forward_stage: RTL and testbench

OPERAND_FORWARD_STAGE -- requirements
Module: operand_forward_stage

---
 rtl/operand_forward_stage_if.sv | 65 ++++++
 rtl/operand_forward_stage.sv | 116 +++++++++++
 tb/tb_operand_forward_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_forward_stage_if.sv
// Decode-to-EX operand bus: decode operands, forwarding sources, hazard
// inputs, and the registered EX-stage results with stall status.
interface operand_forward_stage_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 8;

  // decode stage
  logic            valid_id;
  logic [AW-1:0]   rs1_address_id;
  logic [AW-1:0]   rs2_address_id;
  logic [AW-1:0]   rd_address_id;
  logic [XLEN-1:0] rs1_data_id;
  logic [XLEN-1:0] rs2_data_id;

  // forwarding requests and sources
  logic            forward_enable_to_rs1_from_mem_stage_signal;
  logic            forward_enable_to_rs2_from_mem_stage_signal;
  logic            forward_enable_to_rs1_from_wb_stage_signal;
  logic            forward_enable_to_rs2_from_wb_stage_signal;
  logic [XLEN-1:0] alu_result_mem_stage;
  logic [XLEN-1:0] writeback_data_wb_stage;

  // load-use detection and pipeline control
  logic            mem_read_alu_stage;
  logic [AW-1:0]   destination_address_alu_stage;
  logic            flush;
  logic            hold_ex;

  // EX stage results
  logic [XLEN-1:0] operand1_ex;
  logic [XLEN-1:0] operand2_ex;
  logic [AW-1:0]   rd_address_ex;
  logic            valid_ex;
  logic            stall_if_id;
  logic [CW-1:0]   stall_count;

  // upstream/bench side
  modport master (
    output valid_id, rs1_address_id, rs2_address_id, rd_address_id,
           rs1_data_id, rs2_data_id,
           forward_enable_to_rs1_from_mem_stage_signal,
           forward_enable_to_rs2_from_mem_stage_signal,
           forward_enable_to_rs1_from_wb_stage_signal,
           forward_enable_to_rs2_from_wb_stage_signal,
           alu_result_mem_stage, writeback_data_wb_stage,
           mem_read_alu_stage, destination_address_alu_stage, flush, hold_ex,
    input  operand1_ex, operand2_ex, rd_address_ex, valid_ex,
           stall_if_id, stall_count
  );

  // stage side
  modport slave (
    input  valid_id, rs1_address_id, rs2_address_id, rd_address_id,
           rs1_data_id, rs2_data_id,
           forward_enable_to_rs1_from_mem_stage_signal,
           forward_enable_to_rs2_from_mem_stage_signal,
           forward_enable_to_rs1_from_wb_stage_signal,
           forward_enable_to_rs2_from_wb_stage_signal,
           alu_result_mem_stage, writeback_data_wb_stage,
           mem_read_alu_stage, destination_address_alu_stage, flush, hold_ex,
    output operand1_ex, operand2_ex, rd_address_ex, valid_ex,
           stall_if_id, stall_count
  );
endinterface

// File: rtl/operand_forward_stage.sv
// ID/EX operand stage: selects forwarded operands, detects load-use hazards,
// inserts a one-cycle bubble, and counts load-use stall cycles.
module operand_forward_stage (
  input logic                    clk,
  input logic                    reset,
  operand_forward_stage_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 8;

  typedef enum logic {RUN = 1'b0, LOAD_STALL = 1'b1} state_t;

  state_t          state_q, state_nxt;
  logic [XLEN-1:0] op1_q, op1_nxt, op1_sel;
  logic [XLEN-1:0] op2_q, op2_nxt, op2_sel;
  logic [AW-1:0]   rd_q, rd_nxt;
  logic            valid_q, valid_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic            hazard;
  logic            stall_c;

  // Mem result is younger than wb, so it wins; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [AW-1:0]   addr,
    input logic            en_mem,
    input logic            en_wb,
    input logic [XLEN-1:0] mem_val,
    input logic [XLEN-1:0] wb_val,
    input logic [XLEN-1:0] rf_val
  );
    logic [XLEN-1:0] res;
    res = rf_val;
    if (addr != AW'(0)) begin
      if (en_mem)     res = mem_val;
      else if (en_wb) res = wb_val;
    end
    return res;
  endfunction

  assign op1_sel = fwd_sel(bus.rs1_address_id,
                           bus.forward_enable_to_rs1_from_mem_stage_signal,
                           bus.forward_enable_to_rs1_from_wb_stage_signal,
                           bus.alu_result_mem_stage, bus.writeback_data_wb_stage,
                           bus.rs1_data_id);
  assign op2_sel = fwd_sel(bus.rs2_address_id,
                           bus.forward_enable_to_rs2_from_mem_stage_signal,
                           bus.forward_enable_to_rs2_from_wb_stage_signal,
                           bus.alu_result_mem_stage, bus.writeback_data_wb_stage,
                           bus.rs2_data_id);

  // Load in ALU stage whose destination feeds a source of the decode instruction.
  assign hazard = bus.valid_id & bus.mem_read_alu_stage
                & (bus.destination_address_alu_stage != AW'(0))
                & ((bus.destination_address_alu_stage == bus.rs1_address_id)
                 | (bus.destination_address_alu_stage == bus.rs2_address_id));

  // Next-state, EX register next values and decode stall; flush > hold > hazard.
  always_comb begin
    state_nxt = state_q;
    op1_nxt   = op1_q;
    op2_nxt   = op2_q;
    rd_nxt    = rd_q;
    valid_nxt = valid_q;
    cnt_nxt   = cnt_q;
    stall_c   = 1'b0;
    if (bus.flush) begin
      valid_nxt = 1'b0;
      state_nxt = RUN;
    end else if (bus.hold_ex) begin
      stall_c = 1'b1;
    end else if ((state_q == RUN) && hazard) begin
      stall_c   = 1'b1;
      state_nxt = LOAD_STALL;
      valid_nxt = 1'b0;
      if (cnt_q != {CW{1'b1}}) cnt_nxt = cnt_q + CW'(1);
    end else begin
      op1_nxt   = op1_sel;
      op2_nxt   = op2_sel;
      rd_nxt    = bus.rd_address_id;
      valid_nxt = bus.valid_id;
      state_nxt = RUN;
    end
    if (reset) stall_c = 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_nxt;
  end

  // EX-stage registers and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      op1_q   <= op1_nxt;
      op2_q   <= op2_nxt;
      rd_q    <= rd_nxt;
      valid_q <= valid_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign bus.operand1_ex   = op1_q;
  assign bus.operand2_ex   = op2_q;
  assign bus.rd_address_ex = rd_q;
  assign bus.valid_ex      = valid_q;
  assign bus.stall_count   = cnt_q;
  assign bus.stall_if_id   = stall_c;
endmodule

// File: tb/tb_operand_forward_stage.sv
// Bench for operand_forward_stage: scoreboard of expected EX-stage contents.
module tb_operand_forward_stage;
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        v;
  } ex_t;

  logic clk;
  logic reset;
  operand_forward_stage_if bus();

  operand_forward_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int          errors;
  int          checks;
  ex_t         sb[$];
  ex_t         cur;
  int unsigned e_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_sel(input logic [4:0] a, input logic em,
                                            input logic ew, input logic [31:0] m,
                                            input logic [31:0] w, input logic [31:0] r);
    if (a == 5'd0) return r;
    if (em) return m;
    if (ew) return w;
    return r;
  endfunction

  function automatic ex_t dut_ex();
    ex_t e;
    e.op1 = bus.operand1_ex;
    e.op2 = bus.operand2_ex;
    e.rd  = bus.rd_address_ex;
    e.v   = bus.valid_ex;
    return e;
  endfunction

  function automatic ex_t model_capture();
    ex_t e;
    e.op1 = model_sel(bus.rs1_address_id, bus.forward_enable_to_rs1_from_mem_stage_signal,
                      bus.forward_enable_to_rs1_from_wb_stage_signal,
                      bus.alu_result_mem_stage, bus.writeback_data_wb_stage, bus.rs1_data_id);
    e.op2 = model_sel(bus.rs2_address_id, bus.forward_enable_to_rs2_from_mem_stage_signal,
                      bus.forward_enable_to_rs2_from_wb_stage_signal,
                      bus.alu_result_mem_stage, bus.writeback_data_wb_stage, bus.rs2_data_id);
    e.rd  = bus.rd_address_id;
    e.v   = bus.valid_id;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_id = 1'b0;
    bus.rs1_address_id = 5'd0;
    bus.rs2_address_id = 5'd0;
    bus.rd_address_id = 5'd0;
    bus.rs1_data_id = 32'd0;
    bus.rs2_data_id = 32'd0;
    bus.forward_enable_to_rs1_from_mem_stage_signal = 1'b0;
    bus.forward_enable_to_rs2_from_mem_stage_signal = 1'b0;
    bus.forward_enable_to_rs1_from_wb_stage_signal = 1'b0;
    bus.forward_enable_to_rs2_from_wb_stage_signal = 1'b0;
    bus.alu_result_mem_stage = 32'd0;
    bus.writeback_data_wb_stage = 32'd0;
    bus.mem_read_alu_stage = 1'b0;
    bus.destination_address_alu_stage = 5'd0;
    bus.flush = 1'b0;
    bus.hold_ex = 1'b0;
  endtask

  task automatic drive_load_use(input logic [4:0] rd, input logic [31:0] d1);
    idle();
    bus.valid_id = 1'b1;
    bus.rs1_address_id = 5'd7;
    bus.rs2_address_id = 5'd3;
    bus.rd_address_id = rd;
    bus.rs1_data_id = d1;
    bus.rs2_data_id = 32'h0000_3333;
    bus.mem_read_alu_stage = 1'b1;
    bus.destination_address_alu_stage = 5'd7;
  endtask

  task automatic test_reset();
    ex_t got;
    idle();
    drive_load_use(5'd4, 32'h1);
    bus.hold_ex = 1'b1;
    reset = 1'b1;
    #3;
    got = dut_ex();
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_ex got=%h exp=0", got); end
    checks++;
    if (bus.stall_count !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_count); end
    checks++;
    if (bus.stall_if_id !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall_if_id); end
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    idle();
    tick();
    cur = '0;
    e_cnt = 0;
  endtask

  task automatic test_priority();
    ex_t got, exp;
    idle();
    bus.valid_id = 1'b1;
    bus.rs1_address_id = 5'd5;
    bus.rs2_address_id = 5'd6;
    bus.rd_address_id = 5'd9;
    bus.rs1_data_id = 32'h0000_0111;
    bus.rs2_data_id = 32'h0000_0222;
    bus.forward_enable_to_rs1_from_mem_stage_signal = 1'b1;
    bus.forward_enable_to_rs1_from_wb_stage_signal = 1'b1;
    bus.forward_enable_to_rs2_from_wb_stage_signal = 1'b1;
    bus.alu_result_mem_stage = 32'hAAAA_0001;
    bus.writeback_data_wb_stage = 32'hBBBB_0002;
    sb.push_back('{32'hAAAA_0001, 32'hBBBB_0002, 5'd9, 1'b1});
    #1;
    checks++;
    if (bus.stall_if_id !== 1'b0) begin errors++; $display("FAIL prio_stall got=%b exp=0", bus.stall_if_id); end
    tick();
    got = dut_ex();
    exp = sb.pop_front();
    cur = exp;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL priority got=%h exp=%h", got, exp); end
  endtask

  task automatic test_x0_guard();
    ex_t got, exp;
    idle();
    bus.valid_id = 1'b1;
    bus.rs1_address_id = 5'd0;
    bus.rs2_address_id = 5'd0;
    bus.rd_address_id = 5'd2;
    bus.rs1_data_id = 32'h0000_1234;
    bus.rs2_data_id = 32'd0;
    bus.forward_enable_to_rs1_from_wb_stage_signal = 1'b1;
    bus.forward_enable_to_rs2_from_mem_stage_signal = 1'b1;
    bus.alu_result_mem_stage = 32'hDEAD_BEEF;
    bus.writeback_data_wb_stage = 32'hFEED_F00D;
    sb.push_back('{32'h0000_1234, 32'd0, 5'd2, 1'b1});
    tick();
    got = dut_ex();
    exp = sb.pop_front();
    cur = exp;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL x0_guard got=%h exp=%h", got, exp); end
  endtask

  task automatic test_back_to_back();
    ex_t got, exp;
    for (int i = 0; i < 24; i++) begin
      idle();
      bus.valid_id = 1'($urandom_range(0, 1));
      bus.rs1_address_id = 5'($urandom_range(0, 31));
      bus.rs2_address_id = 5'($urandom_range(0, 31));
      bus.rd_address_id = 5'($urandom_range(0, 31));
      bus.rs1_data_id = $urandom;
      bus.rs2_data_id = $urandom;
      bus.forward_enable_to_rs1_from_mem_stage_signal = 1'($urandom_range(0, 1));
      bus.forward_enable_to_rs2_from_mem_stage_signal = 1'($urandom_range(0, 1));
      bus.forward_enable_to_rs1_from_wb_stage_signal = 1'($urandom_range(0, 1));
      bus.forward_enable_to_rs2_from_wb_stage_signal = 1'($urandom_range(0, 1));
      bus.alu_result_mem_stage = $urandom;
      bus.writeback_data_wb_stage = $urandom;
      bus.mem_read_alu_stage = 1'($urandom_range(0, 1));
      bus.destination_address_alu_stage = bus.mem_read_alu_stage ? 5'd0 : 5'($urandom_range(0, 31));
      sb.push_back(model_capture());
      tick();
      got = dut_ex();
      exp = sb.pop_front();
      cur = exp;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_load_use();
    ex_t got, exp;
    drive_load_use(5'd10, 32'h0000_7777);
    #1;
    checks++;
    if (bus.stall_if_id !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", bus.stall_if_id); end
    sb.push_back('{cur.op1, cur.op2, cur.rd, 1'b0});
    e_cnt++;
    tick();
    got = dut_ex();
    exp = sb.pop_front();
    cur = exp;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lu_bubble got=%h exp=%h", got, exp); end
    checks++;
    if (bus.stall_count !== 8'(e_cnt)) begin errors++; $display("FAIL lu_cnt got=%0d exp=%0d", bus.stall_count, e_cnt); end
    bus.forward_enable_to_rs1_from_mem_stage_signal = 1'b1;
    bus.alu_result_mem_stage = 32'hCAFE_0007;
    #1;
    checks++;
    if (bus.stall_if_id !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", bus.stall_if_id); end
    sb.push_back('{32'hCAFE_0007, 32'h0000_3333, 5'd10, 1'b1});
    tick();
    got = dut_ex();
    exp = sb.pop_front();
    cur = exp;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lu_capture got=%h exp=%h", got, exp); end
    checks++;
    if (bus.stall_count !== 8'(e_cnt)) begin errors++; $display("FAIL lu_cnt2 got=%0d exp=%0d", bus.stall_count, e_cnt); end
  endtask

  task automatic test_flush();
    ex_t got, exp;
    drive_load_use(5'd11, 32'h0000_0055);
    bus.flush = 1'b1;
    bus.hold_ex = 1'b1;
    #1;
    checks++;
    if (bus.stall_if_id !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", bus.stall_if_id); end
    sb.push_back('{cur.op1, cur.op2, cur.rd, 1'b0});
    tick();
    got = dut_ex();
    exp = sb.pop_front();
    cur = exp;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL flush_ex got=%h exp=%h", got, exp); end
    checks++;
    if (bus.stall_count !== 8'(e_cnt)) begin errors++; $display("FAIL flush_cnt got=%0d exp=%0d", bus.stall_count, e_cnt); end
    bus.flush = 1'b0;
    bus.hold_ex = 1'b0;
    #1;
    checks++;
    if (bus.stall_if_id !== 1'b1) begin errors++; $display("FAIL flush_run got=%b exp=1", bus.stall_if_id); end
    e_cnt++;
    tick();
    sb.push_back(model_capture());
    tick();
    got = dut_ex();
    exp = sb.pop_front();
    cur = exp;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL flush_after got=%h exp=%h", got, exp); end
  endtask

  task automatic test_hold();
    ex_t got, exp;
    for (int i = 0; i < 3; i++) begin
      drive_load_use(5'($urandom_range(1, 31)), $urandom);
      bus.mem_read_alu_stage = 1'(i);
      bus.alu_result_mem_stage = $urandom;
      bus.forward_enable_to_rs1_from_mem_stage_signal = 1'b1;
      bus.hold_ex = 1'b1;
      #1;
      checks++;
      if (bus.stall_if_id !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, bus.stall_if_id); end
      sb.push_back(cur);
      tick();
      got = dut_ex();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL hold_ex[%0d] got=%h exp=%h", i, got, exp); end
      checks++;
      if (bus.stall_count !== 8'(e_cnt)) begin errors++; $display("FAIL hold_cnt[%0d] got=%0d exp=%0d", i, bus.stall_count, e_cnt); end
    end
    idle();
    bus.valid_id = 1'b1;
    bus.rs1_address_id = 5'd12;
    bus.rs2_address_id = 5'd13;
    bus.rd_address_id = 5'd14;
    bus.rs1_data_id = 32'h0101_0101;
    bus.forward_enable_to_rs2_from_wb_stage_signal = 1'b1;
    bus.writeback_data_wb_stage = 32'h0202_0202;
    sb.push_back('{32'h0101_0101, 32'h0202_0202, 5'd14, 1'b1});
    tick();
    got = dut_ex();
    exp = sb.pop_front();
    cur = exp;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL hold_release got=%h exp=%h", got, exp); end
  endtask

  task automatic test_saturation_and_reset();
    ex_t got;
    for (int i = 0; i < 260; i++) begin
      drive_load_use(5'd15, 32'h0000_000F);
      tick();
      if (e_cnt < 255) e_cnt++;
      checks++;
      if (bus.stall_count !== 8'(e_cnt)) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, bus.stall_count, e_cnt); end
      bus.mem_read_alu_stage = 1'b0;
      tick();
    end
    drive_load_use(5'd16, 32'h0000_0010);
    tick();
    #2;
    reset = 1'b1;
    #1;
    got = dut_ex();
    checks++;
    if (got !== '0) begin errors++; $display("FAIL rst_mid_ex got=%h exp=0", got); end
    checks++;
    if (bus.stall_count !== 8'd0) begin errors++; $display("FAIL rst_mid_cnt got=%0d exp=0", bus.stall_count); end
    checks++;
    if (bus.stall_if_id !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got=%b exp=0", bus.stall_if_id); end
    @(negedge clk);
    reset = 1'b0;
    e_cnt = 0;
    #1;
    checks++;
    if (bus.stall_if_id !== 1'b1) begin errors++; $display("FAIL rst_run_stall got=%b exp=1", bus.stall_if_id); end
    @(posedge clk);
    #1;
    e_cnt++;
    got = dut_ex();
    checks++;
    if (got !== '0) begin errors++; $display("FAIL rst_run_bubble got=%h exp=0", got); end
    checks++;
    if (bus.stall_count !== 8'(e_cnt)) begin errors++; $display("FAIL rst_run_cnt got=%0d exp=%0d", bus.stall_count, e_cnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    test_reset();
    test_priority();
    test_x0_guard();
    test_back_to_back();
    test_load_use();
    test_flush();
    test_hold();
    test_saturation_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
